eth_tx_framer: RTL and testbench



---
 rtl/eth_tx_framer_pkg.sv | 37 +++
 rtl/crc32_d8.sv | 18 +
 rtl/eth_tx_framer.sv | 189 ++++++++++++++++++
 tb/tb_eth_tx_framer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_framer_pkg.sv
// Shared constants, state type and FCS byte helper for the Ethernet transmit framer
// and the CRC-32 byte step.
package eth_tx_framer_pkg;

  localparam int CRC_LEN    = 32;
  localparam int DATA_LEN   = 8;
  localparam int BYTE_CNT_W = 11;

  localparam logic [CRC_LEN-1:0]  CRC_POLY      = 32'hEDB88320;
  localparam logic [CRC_LEN-1:0]  CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [DATA_LEN-1:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [DATA_LEN-1:0] SFD_BYTE      = 8'hD5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_PAYLOAD,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } eth_tx_state_t;

  // FCS goes out least-significant byte first, taken from the complemented CRC.
  function automatic logic [DATA_LEN-1:0] fcs_byte(input logic [CRC_LEN-1:0] crc,
                                                   input logic [1:0] idx);
    logic [CRC_LEN-1:0] fcs;
    fcs = ~crc;
    case (idx)
      2'd0:    return fcs[7:0];
      2'd1:    return fcs[15:8];
      2'd2:    return fcs[23:16];
      default: return fcs[31:24];
    endcase
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 (IEEE 802.3, reflected) step over one data byte, LSB first.
// Shared between the TX framer and the RX FCS checker.
module crc32_d8
  import eth_tx_framer_pkg::*;
(
  input  logic [CRC_LEN-1:0]  crc,
  input  logic [DATA_LEN-1:0] data,
  output logic [CRC_LEN-1:0]  crc_next
);

  always_comb begin
    crc_next = crc ^ {{(CRC_LEN-DATA_LEN){1'b0}}, data};
    for (int i = 0; i < DATA_LEN; i++) begin
      crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC_POLY) : (crc_next >> 1);
    end
  end

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: preamble, SFD, payload, zero pad to MIN_LEN, FCS,
// then an enforced inter-frame gap. Byte-serial valid/ready on both sides.
module eth_tx_framer
  import eth_tx_framer_pkg::*;
#(
  parameter int MIN_LEN = 60,
  parameter int IFG_LEN = 12,
  parameter int PRE_LEN = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       frame_done
);

  localparam int PRE_W = $clog2(PRE_LEN + 1);
  localparam int IFG_W = $clog2(IFG_LEN + 1);
  localparam logic [BYTE_CNT_W:0] MIN_LEN_W = (BYTE_CNT_W+1)'(MIN_LEN);

  eth_tx_state_t state_reg, state_next;

  logic [CRC_LEN-1:0]    crc_reg, crc_next, crc_step;
  logic [DATA_LEN-1:0]   crc_in;
  logic [BYTE_CNT_W-1:0] byte_cnt_reg, byte_cnt_next, byte_cnt_sat;
  logic [BYTE_CNT_W:0]   byte_cnt_inc;
  logic [PRE_W-1:0]      pre_cnt_reg, pre_cnt_next;
  logic [IFG_W-1:0]      ifg_cnt_reg, ifg_cnt_next;
  logic [2:0]            fcs_cnt_reg, fcs_cnt_next;
  logic [7:0]            m_data_reg, m_data_next;
  logic                  m_valid_reg, m_valid_next;
  logic                  m_last_reg, m_last_next;
  logic                  out_free;

  // The output register can take a new byte when empty or when its byte leaves now.
  assign out_free   = !m_valid_reg || m_ready;
  assign s_ready    = (state_reg == ST_PAYLOAD) && out_free;
  assign m_data     = m_data_reg;
  assign m_valid    = m_valid_reg;
  assign m_last     = m_last_reg;
  assign frame_done = m_valid_reg && m_ready && m_last_reg;

  assign crc_in       = (state_reg == ST_PAD) ? 8'h00 : s_data;
  assign byte_cnt_inc = {1'b0, byte_cnt_reg} + (BYTE_CNT_W+1)'(1);
  assign byte_cnt_sat = byte_cnt_inc[BYTE_CNT_W] ? byte_cnt_reg : byte_cnt_inc[BYTE_CNT_W-1:0];

  crc32_d8 u_crc32_d8 (
    .crc      (crc_reg),
    .data     (crc_in),
    .crc_next (crc_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      crc_reg      <= CRC_INIT;
      byte_cnt_reg <= '0;
      pre_cnt_reg  <= '0;
      ifg_cnt_reg  <= '0;
      fcs_cnt_reg  <= '0;
      m_data_reg   <= '0;
      m_valid_reg  <= 1'b0;
      m_last_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      crc_reg      <= crc_next;
      byte_cnt_reg <= byte_cnt_next;
      pre_cnt_reg  <= pre_cnt_next;
      ifg_cnt_reg  <= ifg_cnt_next;
      fcs_cnt_reg  <= fcs_cnt_next;
      m_data_reg   <= m_data_next;
      m_valid_reg  <= m_valid_next;
      m_last_reg   <= m_last_next;
    end
  end

  // Each state decides what to load into the output register when it is free.
  // SFD is loaded on leaving ST_SFD, so PAYLOAD can accept its first byte on the
  // very cycle the SFD handshakes and the stream has no bubble there.
  always_comb begin
    state_next    = state_reg;
    crc_next      = crc_reg;
    byte_cnt_next = byte_cnt_reg;
    pre_cnt_next  = pre_cnt_reg;
    ifg_cnt_next  = ifg_cnt_reg;
    fcs_cnt_next  = fcs_cnt_reg;
    m_data_next   = m_data_reg;
    m_valid_next  = m_valid_reg;
    m_last_next   = m_last_reg;

    unique case (state_reg)
      ST_IDLE: begin
        crc_next      = CRC_INIT;
        byte_cnt_next = '0;
        pre_cnt_next  = '0;
        fcs_cnt_next  = '0;
        m_valid_next  = 1'b0;
        m_last_next   = 1'b0;
        if (s_valid) begin
          m_data_next  = PREAMBLE_BYTE;
          m_valid_next = 1'b1;
          pre_cnt_next = PRE_W'(1);
          state_next   = (PRE_LEN == 1) ? ST_SFD : ST_PRE;
        end
      end

      ST_PRE: begin
        if (out_free) begin
          m_data_next  = PREAMBLE_BYTE;
          m_valid_next = 1'b1;
          pre_cnt_next = pre_cnt_reg + PRE_W'(1);
          if (pre_cnt_next == PRE_W'(PRE_LEN)) begin
            state_next = ST_SFD;
          end
        end
      end

      ST_SFD: begin
        if (out_free) begin
          m_data_next  = SFD_BYTE;
          m_valid_next = 1'b1;
          state_next   = ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        if (out_free) begin
          if (s_valid) begin
            m_data_next   = s_data;
            m_valid_next  = 1'b1;
            crc_next      = crc_step;
            byte_cnt_next = byte_cnt_sat;
            if (s_last) begin
              state_next = (byte_cnt_inc < MIN_LEN_W) ? ST_PAD : ST_FCS;
            end
          end else begin
            // Source underrun: emit a bubble and keep waiting for the payload.
            m_valid_next = 1'b0;
          end
        end
      end

      ST_PAD: begin
        if (out_free) begin
          m_data_next   = 8'h00;
          m_valid_next  = 1'b1;
          crc_next      = crc_step;
          byte_cnt_next = byte_cnt_sat;
          if (byte_cnt_inc >= MIN_LEN_W) begin
            state_next = ST_FCS;
          end
        end
      end

      ST_FCS: begin
        if (out_free) begin
          if (fcs_cnt_reg == 3'd4) begin
            m_valid_next = 1'b0;
            m_last_next  = 1'b0;
            ifg_cnt_next = '0;
            state_next   = ST_IFG;
          end else begin
            m_data_next  = fcs_byte(crc_reg, fcs_cnt_reg[1:0]);
            m_valid_next = 1'b1;
            m_last_next  = (fcs_cnt_reg == 3'd3);
            fcs_cnt_next = fcs_cnt_reg + 3'd1;
          end
        end
      end

      ST_IFG: begin
        m_valid_next = 1'b0;
        ifg_cnt_next = ifg_cnt_reg + IFG_W'(1);
        if (ifg_cnt_reg == IFG_W'(IFG_LEN - 1)) begin
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Self-checking bench for eth_tx_framer: a vector table of frames on a MIN_LEN=60
// instance, the "123456789" check on a MIN_LEN=9 instance, and a mid-frame reset.
module tb_eth_tx_framer;

  localparam int IFG_LEN = 12;
  localparam int PRE_LEN = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] s_data = '0, m_data;
  logic       s_valid = 1'b0, s_last = 1'b0, s_ready, m_valid, m_last, frame_done;
  logic       m_ready = 1'b1;

  logic [7:0] s_data9 = '0, m_data9;
  logic       s_valid9 = 1'b0, s_last9 = 1'b0, s_ready9, m_valid9, m_last9, frame_done9;
  logic       m_ready9 = 1'b1;

  eth_tx_framer #(.MIN_LEN(60), .IFG_LEN(IFG_LEN), .PRE_LEN(PRE_LEN)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .frame_done(frame_done)
  );

  eth_tx_framer #(.MIN_LEN(9), .IFG_LEN(IFG_LEN), .PRE_LEN(PRE_LEN)) dut9 (
    .clk(clk), .rst(rst),
    .s_data(s_data9), .s_valid(s_valid9), .s_last(s_last9), .s_ready(s_ready9),
    .m_data(m_data9), .m_valid(m_valid9), .m_last(m_last9), .m_ready(m_ready9),
    .frame_done(frame_done9)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: table-driven CRC-32 over the padded body, plus framing.
  logic [31:0] crc_tab [256];

  task automatic build_crc_table();
    logic [31:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[i] = c;
    end
  endtask

  task automatic build_frame(input logic [7:0] pl[$], input int min_len, output logic [7:0] fr[$]);
    logic [7:0]  body[$];
    logic [31:0] c;
    body = pl;
    while (body.size() < min_len) body.push_back(8'h00);
    fr.delete();
    repeat (PRE_LEN) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    c = 32'hFFFFFFFF;
    foreach (body[i]) begin
      fr.push_back(body[i]);
      c = crc_tab[c[7:0] ^ body[i]] ^ (c >> 8);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) fr.push_back(c[8*k +: 8]);
  endtask

  // Downstream ready: always 1, or a 50% coin flip when backpressure is on.
  bit bp_mode = 1'b0;
  always @(posedge clk) begin
    #1;
    m_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor for the MIN_LEN=60 instance, sampled mid-cycle.
  logic [7:0] rx_d[$];
  bit         rx_l[$];
  int cyc = 0, first_cyc = -1, last_cyc = -1, frames_seen = 0, done_cnt = 0;
  int ifg_left = 0, ifg_viol = 0, stall_bad = 0;
  bit stall_prev = 1'b0;
  logic [7:0] stall_d;
  logic       stall_l;

  always @(negedge clk) begin
    cyc++;
    if (frame_done) done_cnt++;
    if (stall_prev && !rst && (!m_valid || m_data !== stall_d || m_last !== stall_l)) stall_bad++;
    stall_prev = m_valid && !m_ready && !rst;
    stall_d = m_data;
    stall_l = m_last;
    if (ifg_left > 0) begin
      if (m_valid) ifg_viol++;
      ifg_left--;
    end
    if (m_valid && m_ready) begin
      rx_d.push_back(m_data);
      rx_l.push_back(m_last);
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      if (m_last) begin
        frames_seen++;
        ifg_left = IFG_LEN;
      end
    end
  end

  logic [7:0] q9_d[$];
  bit         q9_l[$];
  int         q9_c[$];
  int cyc9 = 0, done9 = 0;

  always @(negedge clk) begin
    cyc9++;
    if (frame_done9) done9++;
    if (m_valid9 && m_ready9) begin
      q9_d.push_back(m_data9);
      q9_l.push_back(m_last9);
      q9_c.push_back(cyc9);
    end
  end

  task automatic drive(input int which, input logic v, input logic [7:0] d, input logic l);
    if (which == 0) begin
      s_valid = v; s_data = d; s_last = l;
    end else begin
      s_valid9 = v; s_data9 = d; s_last9 = l;
    end
  endtask

  // Present one payload; a 3-cycle s_valid gap precedes every gap_every-th byte.
  task automatic send(input int which, input logic [7:0] pl[$], input int gap_every);
    bit hs;
    int budget;
    for (int i = 0; i < pl.size(); i++) begin
      if (gap_every > 0 && i > 0 && (i % gap_every) == 0) begin
        drive(which, 1'b0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
      end
      drive(which, 1'b1, pl[i], i == pl.size() - 1);
      hs = 1'b0;
      budget = 0;
      while (!hs && budget < 2000) begin
        @(negedge clk);
        hs = (which == 0) ? s_ready : s_ready9;
        budget++;
        @(posedge clk);
        #1;
      end
      if (!hs) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: byte %0d accepted=0, required accepted=1 within 2000 cycles", i);
        drive(which, 1'b0, 8'h00, 1'b0);
        return;
      end
    end
    drive(which, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_frames(input int target);
    int budget = 0;
    while (frames_seen < target && budget < 5000) begin
      @(posedge clk);
      budget++;
    end
    check("frame_complete", 64'(frames_seen >= target), 64'd1);
    repeat (IFG_LEN + 3) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rx_d.delete();
    rx_l.delete();
    first_cyc = -1;
    last_cyc  = -1;
    ifg_viol  = 0;
    stall_bad = 0;
  endtask

  task automatic compare_bytes(input string name, input logic [7:0] got[$], input logic [7:0] exp[$]);
    int mism = 0;
    for (int i = 0; i < exp.size(); i++) begin
      if (i >= got.size() || got[i] !== exp[i]) mism++;
    end
    check(name, 64'(mism), 64'd0);
  endtask

  typedef struct {
    int len;
    int gap_every;
    bit bp;
    bit reuse;
    int exp_len;
    int exp_gaps;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  initial begin
    logic [7:0] pl[$], pl9[$], exp[$], exp9[$], prev_rx[$];
    int f0, d0, nlast, lastidx, gap;

    vecs[0] = '{1,   0, 1'b0, 1'b0, 72,  0};
    vecs[1] = '{64,  0, 1'b0, 1'b0, 76,  0};
    vecs[2] = '{100, 0, 1'b0, 1'b0, 112, 0};
    vecs[3] = '{100, 0, 1'b1, 1'b1, 112, 0};
    vecs[4] = '{30, 10, 1'b0, 1'b0, 72,  2};
    vecs[5] = '{60,  0, 1'b0, 1'b0, 72,  0};
    vecs[6] = '{59,  0, 1'b0, 1'b0, 72,  0};
    vecs[7] = '{61,  0, 1'b0, 1'b0, 73,  0};
    vecs[8] = '{80,  7, 1'b1, 1'b0, 92,  0};

    build_crc_table();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", 64'(m_data), 64'h00);
    check("rst_m_last", 64'(m_last), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // "123456789" with MIN_LEN=9, sent twice back to back.
    for (int i = 0; i < 9; i++) pl9.push_back(8'h31 + 8'(i));
    repeat (PRE_LEN) exp9.push_back(8'h55);
    exp9.push_back(8'hD5);
    foreach (pl9[i]) exp9.push_back(pl9[i]);
    exp9.push_back(8'h26); exp9.push_back(8'h39); exp9.push_back(8'hF4); exp9.push_back(8'hCB);

    drive(1, 1'b1, pl9[0], 1'b0);
    @(negedge clk);
    check("pre_latency_before", 64'(m_valid9), 64'd0);
    @(negedge clk);
    check("pre_latency_valid", 64'(m_valid9), 64'd1);
    check("pre_first_byte", 64'(m_data9), 64'h55);
    @(posedge clk);
    #1;
    send(1, pl9, 0);
    send(1, pl9, 0);
    begin
      int budget = 0;
      while (done9 < 2 && budget < 3000) begin
        @(posedge clk);
        budget++;
      end
    end
    repeat (IFG_LEN + 3) @(posedge clk);
    #1;
    check("crc9_len", 64'(q9_d.size()), 64'd42);
    compare_bytes("crc9_frame1", q9_d[0:20], exp9);
    compare_bytes("crc9_frame2", q9_d[21:41], exp9);
    nlast = 0;
    foreach (q9_l[i]) nlast += int'(q9_l[i]);
    check("crc9_last_count", 64'(nlast), 64'd2);
    check("crc9_last_pos", 64'({q9_l[20], q9_l[41]}), 64'b11);
    check("crc9_frame_done", 64'(done9), 64'd2);
    check("crc9_no_bubbles", 64'(q9_c[20] - q9_c[0]), 64'd20);
    gap = q9_c[21] - q9_c[20] - 1;
    check("crc9_ifg", 64'(gap >= IFG_LEN && gap <= IFG_LEN + 1), 64'd1);
    $display("frame crc9: bytes=%0d done=%0d idle_gap=%0d", q9_d.size(), done9, gap);

    for (int v = 0; v < NV; v++) begin
      if (!vecs[v].reuse) begin
        pl.delete();
        for (int i = 0; i < vecs[v].len; i++)
          pl.push_back(vecs[v].len == 1 ? 8'hAB : 8'($urandom_range(0, 255)));
      end
      build_frame(pl, 60, exp);
      clear_mon();
      f0 = frames_seen;
      d0 = done_cnt;
      bp_mode = vecs[v].bp;
      send(0, pl, vecs[v].gap_every);
      wait_frames(f0 + 1);
      bp_mode = 1'b0;
      check($sformatf("v%0d_len", v), 64'(rx_d.size()), 64'(vecs[v].exp_len));
      compare_bytes($sformatf("v%0d_bytes", v), rx_d, exp);
      nlast = 0;
      lastidx = -1;
      foreach (rx_l[i]) if (rx_l[i]) begin nlast++; lastidx = i; end
      check($sformatf("v%0d_last_pos", v), 64'(lastidx), 64'(vecs[v].exp_len - 1));
      check($sformatf("v%0d_last_count", v), 64'(nlast), 64'd1);
      check($sformatf("v%0d_frame_done", v), 64'(done_cnt - d0), 64'd1);
      check($sformatf("v%0d_ifg_idle", v), 64'(ifg_viol), 64'd0);
      if (!vecs[v].bp)
        check($sformatf("v%0d_span", v), 64'(last_cyc - first_cyc + 1),
              64'(vecs[v].exp_len + 3 * vecs[v].exp_gaps));
      else
        check($sformatf("v%0d_stall_stable", v), 64'(stall_bad), 64'd0);
      if (vecs[v].reuse) compare_bytes($sformatf("v%0d_same_as_prev", v), rx_d, prev_rx);
      prev_rx = rx_d;
      $display("frame v%0d: payload=%0d bp=%0d gap_every=%0d out_bytes=%0d span=%0d",
               v, vecs[v].len, vecs[v].bp, vecs[v].gap_every, rx_d.size(), last_cyc - first_cyc + 1);
    end

    // Reset during PAD drops the frame; the next frame starts clean.
    pl.delete();
    for (int i = 0; i < 10; i++) pl.push_back(8'($urandom_range(0, 255)));
    clear_mon();
    f0 = frames_seen;
    d0 = done_cnt;
    send(0, pl, 0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_m_valid", 64'(m_valid), 64'd0);
    check("midrst_m_data", 64'(m_data), 64'h00);
    check("midrst_m_last", 64'(m_last), 64'd0);
    check("midrst_s_ready", 64'(s_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    nlast = 0;
    foreach (rx_l[i]) nlast += int'(rx_l[i]);
    check("midrst_no_fcs_last", 64'(nlast), 64'd0);
    check("midrst_no_frame_done", 64'(done_cnt - d0), 64'd0);
    check("midrst_truncated", 64'(rx_d.size() < 72), 64'd1);
    $display("frame reset_drop: bytes_before_reset=%0d", rx_d.size());

    pl.delete();
    for (int i = 0; i < 20; i++) pl.push_back(8'($urandom_range(0, 255)));
    build_frame(pl, 60, exp);
    clear_mon();
    f0 = frames_seen;
    d0 = done_cnt;
    send(0, pl, 0);
    wait_frames(f0 + 1);
    check("postrst_len", 64'(rx_d.size()), 64'd72);
    compare_bytes("postrst_bytes", rx_d, exp);
    check("postrst_frame_done", 64'(done_cnt - d0), 64'd1);
    $display("frame post_reset: payload=20 out_bytes=%0d", rx_d.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
